// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    DONE   = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: extracts/extends load data and merges sub-word
// store data into the word read from RAM.
module lsu_align
  import mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);

  logic [1:0]  bl;
  logic        hl;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    // big-endian simply mirrors the lane index within the word
    bl         = (BIG_ENDIAN != 0) ? ~lane : lane;
    hl         = (BIG_ENDIAN != 0) ? ~lane[1] : lane[1];
    b          = word[8*bl +: 8];
    h          = word[16*hl +: 16];
    load_val   = word;
    merge_word = word;
    case (size)
      SZ_BYTE: begin
        load_val               = {{24{~uns & b[7]}}, b};
        merge_word[8*bl +: 8]  = wdata[7:0];
      end
      SZ_HALF: begin
        load_val               = {{16{~uns & h[15]}}, h};
        merge_word[16*hl +: 16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: turns byte/half/word requests into word RAM accesses,
// using read-modify-write for sub-word stores.
//
//  state  | meaning
//  IDLE   | ready, accepts a request and runs the alignment check
//  ACCESS | RAM addressed; load captured, SW written, or SB/SH merge built
//  WRITE  | merged word written back for SB/SH
//  DONE   | one-cycle done pulse, err if the request was rejected
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  lsu_state_e        state, state_nx;
  logic              wr_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, merge_q;
  logic [31:0]       load_val, merge_word;
  logic              bad_req, sub_store;

  assign bad_req = (size == 2'b11) ||
                   (size == SZ_HALF && addr[0]) ||
                   (size == SZ_WORD && addr[1:0] != 2'b00);
  assign sub_store = wr_q && (size_q != SZ_WORD);

  lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .word       (ram_dout),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q[15:0]),
    .load_val   (load_val),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata   <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        wr_q    <= wr;
        uns_q   <= uns;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= bad_req;
      end
      if (state == ACCESS) begin
        merge_q <= merge_word;
        if (!wr_q) rdata <= load_val;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ram_din  = 32'h0;
    ram_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nx = bad_req ? DONE : ACCESS;
      end
      ACCESS: begin
        state_nx = sub_store ? WRITE : DONE;
        if (wr_q && !sub_store) begin
          ram_we  = 1'b1;
          ram_din = wdata_q;
        end
      end
      WRITE: begin
        state_nx = DONE;
        ram_we   = 1'b1;
        ram_din  = merge_q;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready    = (state == IDLE);
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_q;
  assign ram_addr = 32'(addr_q[ADDR_W-1:2]);

endmodule
